// File: rtl/mem_stage_pkg.sv
// Shared MEM-stage definitions: bus widths, stall encoding, load-op codes and bus layouts.
// Pure definitions, no latency or backpressure of their own.
package mem_stage_pkg;

  localparam int EX_TO_MEM_WD = 79;
  localparam int MEM_TO_WB_WD = 70;
  localparam int MEM_TO_ID_WD = 38;
  localparam int StallBus     = 6;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  localparam int STALL_MEM = 3;
  localparam int STALL_WB  = 4;

  localparam logic [2:0] MEM_OP_LW  = 3'b000;
  localparam logic [2:0] MEM_OP_LB  = 3'b001;
  localparam logic [2:0] MEM_OP_LBU = 3'b010;
  localparam logic [2:0] MEM_OP_LH  = 3'b011;
  localparam logic [2:0] MEM_OP_LHU = 3'b100;

  typedef struct packed {
    logic [31:0] pc;
    logic [2:0]  mem_op;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
  } ex_to_mem_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
  } mem_to_wb_t;

  typedef struct packed {
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
  } mem_to_id_t;

  function automatic logic load_op(input ex_to_mem_t b);
    return b.data_ram_en & (b.data_ram_wen == 4'b0000) & b.sel_rf_res;
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Little-endian byte/half/word extraction with sign or zero extension.
// Combinational, no backpressure.
module mem_load_ext
  import mem_stage_pkg::*;
(
  input  logic [31:0] eff_rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  mem_op,
  output logic [31:0] load_value
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel   = eff_rdata[{addr, 3'b000} +: 8];
    half_sel   = addr[1] ? eff_rdata[31:16] : eff_rdata[15:0];
    load_value = eff_rdata;
    // Unlisted encodings behave as LW; misaligned low bits are simply dropped.
    case (mem_op)
      MEM_OP_LB:  load_value = {{24{byte_sel[7]}}, byte_sel};
      MEM_OP_LBU: load_value = {24'd0, byte_sel};
      MEM_OP_LH:  load_value = {{16{half_sel[15]}}, half_sel};
      MEM_OP_LHU: load_value = {16'd0, half_sel};
      default:    load_value = eff_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: registers the EX bundle, extends SRAM load data, drives WB and ID forwarding buses.
// One register stage; stall[3] holds or bubbles, a hold buffer keeps load data across WB stalls.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [StallBus-1:0]     stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [31:0]             data_sram_rdata,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [MEM_TO_ID_WD-1:0] mem_to_id_bus
);

  ex_to_mem_t  mem_q;
  logic        hold_valid;
  logic [31:0] hold_data;
  logic        is_load;
  logic        bubble;
  logic        advance;
  logic        capture;
  logic [31:0] eff_rdata;
  logic [31:0] load_value;
  logic [31:0] rf_wdata;
  mem_to_wb_t  wb;
  mem_to_id_t  id;
  logic        stall_unused;

  assign stall_unused = ^{stall[5], stall[2:0]};

  assign bubble  = (stall[STALL_MEM] == Stop) && (stall[STALL_WB] == NoStop);
  assign advance = (stall[STALL_MEM] == NoStop);
  assign is_load = load_op(mem_q);
  // Only the first MEM cycle of a stalled load sees the SRAM word it asked for.
  assign capture = (stall[STALL_WB] == Stop) && !hold_valid && is_load;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q      <= '0;
      hold_valid <= 1'b0;
      hold_data  <= 32'd0;
    end else if (bubble) begin
      mem_q      <= '0;
      hold_valid <= 1'b0;
    end else if (advance) begin
      mem_q      <= ex_to_mem_t'(ex_to_mem_bus);
      hold_valid <= 1'b0;
    end else if (capture) begin
      hold_data  <= data_sram_rdata;
      hold_valid <= 1'b1;
    end
  end

  assign eff_rdata = hold_valid ? hold_data : data_sram_rdata;

  mem_load_ext u_load_ext (
    .eff_rdata  (eff_rdata),
    .addr       (mem_q.ex_result[1:0]),
    .mem_op     (mem_q.mem_op),
    .load_value (load_value)
  );

  assign rf_wdata = is_load ? load_value : mem_q.ex_result;

  always_comb begin
    wb.pc       = mem_q.pc;
    wb.rf_we    = mem_q.rf_we;
    wb.rf_waddr = mem_q.rf_waddr;
    wb.rf_wdata = rf_wdata;
    id.rf_we    = mem_q.rf_we;
    id.rf_waddr = mem_q.rf_waddr;
    id.rf_wdata = rf_wdata;
  end

  assign mem_to_wb_bus = wb;
  assign mem_to_id_bus = id;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table through a scoreboard plus stall/bubble/reset sequences.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic                    clk;
  logic                    rst;
  logic [StallBus-1:0]     stall;
  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
  logic [31:0]             data_sram_rdata;
  logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus;
  logic [MEM_TO_ID_WD-1:0] mem_to_id_bus;

  int checks = 0;
  int errors = 0;

  logic [69:0] exp_q[$];

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [2:0]  op;
    logic        en;
    logic [3:0]  wen;
    logic        sel;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] res;
    logic [31:0] rdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  mem_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .ex_to_mem_bus   (ex_to_mem_bus),
    .data_sram_rdata (data_sram_rdata),
    .mem_to_wb_bus   (mem_to_wb_bus),
    .mem_to_id_bus   (mem_to_id_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [78:0] mk_ex(input logic [31:0] pc, input logic [2:0] op,
                                        input logic en, input logic [3:0] wen, input logic sel,
                                        input logic we, input logic [4:0] waddr,
                                        input logic [31:0] res);
    return {pc, op, en, wen, sel, we, waddr, res};
  endfunction

  task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Compares WB and ID buses against the scoreboard head; optionally retires it.
  task automatic check_head(input string name, input bit pop);
    logic [69:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, got %h", name, mem_to_wb_bus);
    end else begin
      e = pop ? exp_q.pop_front() : exp_q[0];
      check({name, "_wb"}, mem_to_wb_bus, e);
      check({name, "_id"}, {32'd0, mem_to_id_bus}, {32'd0, e[37:0]});
    end
  endtask

  initial begin
    vecs[0]  = '{"alu",      32'hBFC00010, MEM_OP_LW,  1'b0, 4'h0, 1'b0, 1'b1, 5'd5,  32'h12345678, 32'hCAFEF00D, 32'h12345678};
    vecs[1]  = '{"lb_a3",    32'hBFC00014, MEM_OP_LB,  1'b1, 4'h0, 1'b1, 1'b1, 5'd6,  32'h10000003, 32'h80FF7F01, 32'hFFFFFF80};
    vecs[2]  = '{"lbu_a3",   32'hBFC00018, MEM_OP_LBU, 1'b1, 4'h0, 1'b1, 1'b1, 5'd7,  32'h10000003, 32'h80FF7F01, 32'h00000080};
    vecs[3]  = '{"lb_a1",    32'hBFC0001C, MEM_OP_LB,  1'b1, 4'h0, 1'b1, 1'b1, 5'd8,  32'h10000001, 32'h80FF7F01, 32'h0000007F};
    vecs[4]  = '{"lh_a2",    32'hBFC00020, MEM_OP_LH,  1'b1, 4'h0, 1'b1, 1'b1, 5'd9,  32'h10000002, 32'h80FF7F01, 32'hFFFF80FF};
    vecs[5]  = '{"lhu_a0",   32'hBFC00024, MEM_OP_LHU, 1'b1, 4'h0, 1'b1, 1'b1, 5'd10, 32'h10000000, 32'h80FF7F01, 32'h00007F01};
    vecs[6]  = '{"lw_a1",    32'hBFC00028, MEM_OP_LW,  1'b1, 4'h0, 1'b1, 1'b1, 5'd11, 32'h10000001, 32'h80FF7F01, 32'h80FF7F01};
    vecs[7]  = '{"lh_a3",    32'hBFC0002C, MEM_OP_LH,  1'b1, 4'h0, 1'b1, 1'b1, 5'd12, 32'h10000003, 32'h80FF7F01, 32'hFFFF80FF};
    vecs[8]  = '{"lbu_a2",   32'hBFC00030, MEM_OP_LBU, 1'b1, 4'h0, 1'b1, 1'b1, 5'd13, 32'h10000002, 32'h80FF7F01, 32'h000000FF};
    vecs[9]  = '{"op101_lw", 32'hBFC00034, 3'b101,     1'b1, 4'h0, 1'b1, 1'b1, 5'd14, 32'h10000002, 32'h80FF7F01, 32'h80FF7F01};
    vecs[10] = '{"store",    32'hBFC00038, MEM_OP_LB,  1'b1, 4'hF, 1'b0, 1'b0, 5'd0,  32'h10000003, 32'h80FF7F01, 32'h10000003};
    vecs[11] = '{"nosel",    32'hBFC0003C, MEM_OP_LB,  1'b1, 4'h0, 1'b0, 1'b1, 5'd15, 32'h20000001, 32'h80FF7F01, 32'h20000001};

    // Reset held with a live, nonzero input bus.
    rst             = 1'b0;
    stall           = 6'b000000;
    data_sram_rdata = 32'h80FF7F01;
    ex_to_mem_bus   = mk_ex(32'h11111111, MEM_OP_LW, 1'b1, 4'h0, 1'b1, 1'b1, 5'd3, 32'h44);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_wb", mem_to_wb_bus, 70'd0);
    check("reset_id", {32'd0, mem_to_id_bus}, 70'd0);
    check("reset_we", {69'd0, mem_to_wb_bus[37]}, 70'd0);
    rst = 1'b1;

    // Table-driven single-cycle vectors.
    for (int i = 0; i < 12; i++) begin
      ex_to_mem_bus = mk_ex(vecs[i].pc, vecs[i].op, vecs[i].en, vecs[i].wen, vecs[i].sel,
                            vecs[i].we, vecs[i].waddr, vecs[i].res);
      exp_q.push_back({vecs[i].pc, vecs[i].we, vecs[i].waddr, vecs[i].exp});
      @(posedge clk);
      #1 data_sram_rdata = vecs[i].rdata;
      @(negedge clk);
      check_head(vecs[i].name, 1'b1);
    end

    // Hold buffer: load word must survive a WB stall while rdata changes.
    ex_to_mem_bus = mk_ex(32'hBFC00100, MEM_OP_LW, 1'b1, 4'h0, 1'b1, 1'b1, 5'd20, 32'h00000100);
    exp_q.push_back({32'hBFC00100, 1'b1, 5'd20, 32'hAAAA5555});
    @(posedge clk);
    #1;
    data_sram_rdata = 32'hAAAA5555;
    stall           = 6'b011111;
    ex_to_mem_bus   = mk_ex(32'hBFC00104, MEM_OP_LW, 1'b0, 4'h0, 1'b0, 1'b1, 5'd21, 32'h0000BEEF);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_head("hold_stall", 1'b0);
      @(posedge clk);
      #1 data_sram_rdata = 32'hDEADBEEF;
    end
    stall = 6'b000000;
    @(negedge clk);
    check_head("hold_release", 1'b1);
    exp_q.push_back({32'hBFC00104, 1'b1, 5'd21, 32'h0000BEEF});
    @(posedge clk);
    @(negedge clk);
    check_head("after_hold", 1'b1);

    // Bubble: previous MEM contents show once, then zeros.
    ex_to_mem_bus = mk_ex(32'hBFC00200, MEM_OP_LW, 1'b0, 4'h0, 1'b0, 1'b1, 5'd9, 32'h00000055);
    exp_q.push_back({32'hBFC00200, 1'b1, 5'd9, 32'h00000055});
    @(posedge clk);
    #1;
    stall         = 6'b001111;
    ex_to_mem_bus = mk_ex(32'hBFC00204, MEM_OP_LW, 1'b0, 4'h0, 1'b0, 1'b1, 5'd10, 32'h00000066);
    @(negedge clk);
    check_head("bubble_prev", 1'b1);
    @(posedge clk);
    #1 stall = 6'b000000;
    @(negedge clk);
    check("bubble_zero", mem_to_wb_bus, 70'd0);
    exp_q.push_back({32'hBFC00204, 1'b1, 5'd10, 32'h00000066});
    @(posedge clk);
    @(negedge clk);
    check_head("bubble_next", 1'b1);

    // Asynchronous reset in the middle of a held load.
    ex_to_mem_bus = mk_ex(32'hBFC00300, MEM_OP_LW, 1'b1, 4'h0, 1'b1, 1'b1, 5'd22, 32'h00000200);
    @(posedge clk);
    #1;
    data_sram_rdata = 32'hAAAA5555;
    stall           = 6'b011111;
    @(posedge clk);
    #1 data_sram_rdata = 32'hDEADBEEF;
    #2 rst = 1'b0;
    #1;
    check("arst_wb", mem_to_wb_bus, 70'd0);
    check("arst_id", {32'd0, mem_to_id_bus}, 70'd0);
    @(negedge clk);
    rst   = 1'b1;
    ex_to_mem_bus = mk_ex(32'hBFC00400, MEM_OP_LW, 1'b1, 4'h0, 1'b1, 1'b1, 5'd23, 32'h00000300);
    // Stall still asserted: MEM keeps the reset bubble, which must not be a captured load.
    @(posedge clk);
    #1 data_sram_rdata = 32'h0BADF00D;
    @(negedge clk);
    check("arst_hold_zero", mem_to_wb_bus, 70'd0);
    stall = 6'b000000;
    exp_q.push_back({32'hBFC00400, 1'b1, 5'd23, 32'h13572468});
    @(posedge clk);
    #1 data_sram_rdata = 32'h13572468;
    @(negedge clk);
    check_head("arst_live", 1'b1);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
